spi_master_lite: RTL and testbench
==================================

// Module: spi_master_lite
// PURPOSE
//   SPI master (mode 0, MSB first) that drives sck/ss/mosi for the SPI
//   peripherals, e.g. the bit-reversal slave, and samples their miso.
//   Host side is a valid/ready command channel and a valid/ready response
//   channel. It runs one transfer at a time, with a programmable sck divider
//   and length.
// PARAMETERS
//   DATA_W  64  max bits per transfer; width of cmd_data/rsp_data
//   SS_W    8   number of slave-select lines (active low)
//   DIV_W   16  width of the sck half-period divider
//   LEN_W   7   width of cmd_len, $clog2(DATA_W)+1
// PORTS
//   clock      in   1       system clock; all logic on its rising edge
//   reset      in   1       asynchronous, active-high reset
//   cmd_valid  in   1       command offered
//   cmd_ready  out  1       high only in IDLE
//   cmd_data   in   DATA_W  tx bits, right-aligned; bit len-1 is sent first
//   cmd_len    in   LEN_W   bits to transfer; 0 or >DATA_W means DATA_W
//   cmd_ss     in   SS_W    one-hot-low select mask copied to ss
//   cmd_div    in   DIV_W   half-period = cmd_div+1 clocks
//   rsp_valid  out  1       received data available
//   rsp_ready  in   1       response consumed
//   rsp_data   out  DATA_W  rx bits, right-aligned; upper bits zero
//   busy       out  1       high in any state except IDLE
//   sck        out  1       SPI clock, idle low
//   ss         out  SS_W    slave selects, idle all ones
//   mosi       out  1       SPI data out, idle 1
//   miso       in   1       SPI data in
// BEHAVIOUR
//   Reset values: sck=0, ss='1, mosi=1, rsp_valid=0, rsp_data=0, busy=0,
//     cmd_ready=1. Reset acts immediately mid-transfer, so ss deasserts.
//   Accept: cmd_valid&&cmd_ready at a clock edge. That edge latches data,
//     len (clamped), ss mask and div. It drives ss=cmd_ss and mosi=bit len-1.
//     Next state is SETUP.
//   Timing: h = div+1 clocks. A half-period counter reloads on every state
//     change.
//   SETUP (h): sck=0, ss asserted, mosi holds the first bit. Then go to HIGH.
//   HIGH (h): sck=1. The slave samples mosi on this rising edge.
//   Exit from HIGH drives sck=0 and shifts rx <= {rx[DATA_W-2:0], miso}.
//     miso is sampled at the falling edge, i.e. after the slave updates it on
//     the rising edge. bit_cnt decrements.
//     If bits remain: mosi = next bit, go to LOW.
//     Otherwise go to HOLD with mosi unchanged.
//   LOW (h): sck=0. Then go to HIGH.
//   HOLD (h): sck=0 with ss still asserted. Exit drives ss='1 and mosi=1,
//     sets rsp_valid=1 and rsp_data=rx. Next state is DONE.
//   DONE: rsp_valid and rsp_data stay stable until rsp_valid&&rsp_ready.
//     Then rsp_valid=0, go to IDLE, and cmd_ready=1 from the next cycle.
//     There is no same-cycle turnaround.
//   Latency: rsp_valid rises exactly (2*len+1)*h clock edges after the
//     accepting edge.
//   rx is cleared on accept, so rsp_data bits >= len are 0.
//   cmd_* inputs are ignored while busy; changing them mid-transfer has no
//     effect.
//   Exactly len rising sck edges per transfer. sck never toggles while ss is
//     deasserted.
// TESTING
//   1. Reset with no command -> sck=0, ss=8'hFF, mosi=1, cmd_ready=1,
//      busy=0, rsp_valid=0.
//   2. len=8, div=0, data=8'hA5, miso tied 0 -> mosi pattern 1,0,1,0,0,1,0,1
//      at 8 sck rises; rsp_valid at edge 17; rsp_data=0.
//   3. Bit-reversal slave on ss[0]: len=16, data=16'h0100 -> rsp_data=16'hFF80.
//      Then data=16'h6A00 -> rsp_data=16'hFF56.
//   4. div=3, len=4 -> sck high/low phases of 4 clocks each; rsp_valid 36
//      edges after accept.
//   5. rsp_ready held low for 10 cycles -> rsp_valid/rsp_data stable,
//      cmd_ready=0. A cmd_valid during this time is not accepted.
//   6. reset asserted mid-bit, then len=0 -> outputs at reset values at once.
//      The next len=0 command transfers 64 bits (64 sck rises).

Source files
------------

// File: rtl/spi_master_lite.sv
// Mode-0, MSB-first SPI master: one transfer per command, with a programmable length
// and sck half-period, and valid/ready command and response channels.
module spi_master_lite #(
    parameter int DATA_W = 64,
    parameter int SS_W   = 8,
    parameter int DIV_W  = 16,
    parameter int LEN_W  = 7
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [DATA_W-1:0] i_cmd_data,
    input  logic [LEN_W-1:0]  i_cmd_len,
    input  logic [SS_W-1:0]   i_cmd_ss,
    input  logic [DIV_W-1:0]  i_cmd_div,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DATA_W-1:0] o_rsp_data,
    output logic              o_busy,
    output logic              o_sck,
    output logic [SS_W-1:0]   o_ss,
    output logic              o_mosi,
    input  logic              i_miso
);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_HIGH, S_LOW, S_HOLD, S_DONE
    } state_t;

    localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(DATA_W);

    state_t            r_state;
    state_t            w_next;
    logic [DIV_W-1:0]  r_div;
    logic [DIV_W-1:0]  r_half_cnt;
    logic [LEN_W-1:0]  r_bit_cnt;
    logic [LEN_W-1:0]  w_len;
    logic [DATA_W-2:0] r_tx;
    logic [DATA_W-1:0] r_rx;
    logic [DATA_W-1:0] w_tx_aligned;
    logic              w_accept;
    logic              w_half_done;
    logic              w_last_bit;

    assign w_len        = (i_cmd_len == '0 || i_cmd_len > FULL_LEN) ? FULL_LEN : i_cmd_len;
    // Left-align the payload so the first bit to send is always the MSB.
    assign w_tx_aligned = i_cmd_data << (FULL_LEN - w_len);
    assign w_accept     = i_cmd_valid && (r_state == S_IDLE);
    assign w_half_done  = (r_half_cnt == '0);
    assign w_last_bit   = (r_bit_cnt == LEN_W'(1));

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)    w_next = S_SETUP;
            S_SETUP: if (w_half_done) w_next = S_HIGH;
            S_HIGH:  if (w_half_done) w_next = w_last_bit ? S_HOLD : S_LOW;
            S_LOW:   if (w_half_done) w_next = S_HIGH;
            S_HOLD:  if (w_half_done) w_next = S_DONE;
            S_DONE:  if (i_rsp_ready) w_next = S_IDLE;
            default:                  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_sck       = 1'b0;
        o_busy      = 1'b1;
        o_cmd_ready = 1'b0;
        o_rsp_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_busy      = 1'b0;
                o_cmd_ready = 1'b1;
            end
            S_HIGH:  o_sck       = 1'b1;
            S_DONE:  o_rsp_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_half_cnt <= '0;
            r_div      <= '0;
            r_bit_cnt  <= '0;
            r_tx       <= '0;
            r_rx       <= '0;
            o_ss       <= '1;
            o_mosi     <= 1'b1;
            o_rsp_data <= '0;
        end else begin
            // Every phase lasts div+1 clocks, so reload on each state change.
            if (w_next != r_state)
                r_half_cnt <= w_accept ? i_cmd_div : r_div;
            else if (!w_half_done)
                r_half_cnt <= r_half_cnt - DIV_W'(1);

            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_div     <= i_cmd_div;
                    r_bit_cnt <= w_len;
                    r_tx      <= w_tx_aligned[DATA_W-2:0];
                    r_rx      <= '0;
                    o_ss      <= i_cmd_ss;
                    o_mosi    <= w_tx_aligned[DATA_W-1];
                end
                S_HIGH: if (w_half_done) begin
                    r_rx      <= {r_rx[DATA_W-2:0], i_miso};
                    r_bit_cnt <= r_bit_cnt - LEN_W'(1);
                    if (!w_last_bit) begin
                        o_mosi <= r_tx[DATA_W-2];
                        r_tx   <= {r_tx[DATA_W-3:0], 1'b0};
                    end
                end
                S_HOLD: if (w_half_done) begin
                    o_ss       <= '1;
                    o_mosi     <= 1'b1;
                    o_rsp_data <= r_rx;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_lite.sv
// Bench for spi_master_lite: directed commands push expected responses into a scoreboard,
// and a monitor checks each handshaked response together with the captured mosi bits.
module tb_spi_master_lite;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [63:0] cmd_data = '0;
    logic [6:0]  cmd_len = '0;
    logic [7:0]  cmd_ss = '1;
    logic [15:0] cmd_div = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [63:0] rsp_data;
    logic        busy;
    logic        sck;
    logic [7:0]  ss;
    logic        mosi;
    logic        miso;

    int   miso_mode = 0;   // 0: tied low, 1: tied high, 2: bit-reversal slave on ss[0]
    logic sl_miso = 1'b1;
    assign miso = (miso_mode == 2) ? sl_miso : (miso_mode == 1);

    spi_master_lite #(.DATA_W(64), .SS_W(8), .DIV_W(16), .LEN_W(7)) dut (
        .i_clock(clock), .i_reset(reset),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
        .i_cmd_data(cmd_data), .i_cmd_len(cmd_len), .i_cmd_ss(cmd_ss), .i_cmd_div(cmd_div),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_data(rsp_data),
        .o_busy(busy), .o_sck(sck), .o_ss(ss), .o_mosi(mosi), .i_miso(miso)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [63:0] rx;
        logic [63:0] tx;
        logic [63:0] len;
    } exp_t;
    exp_t sb_q[$];

    // Byte-framed slave: returns 0xFF first, then each received byte bit-reversed.
    logic [7:0] sl_tx = 8'hFF;
    logic [7:0] sl_rx = '0;
    int         sl_cnt = 0;
    logic       sl_prev_sck = 1'b0;

    function automatic logic [7:0] rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
    endfunction

    always @(negedge clock) begin
        if (ss[0]) begin
            sl_tx  = 8'hFF;
            sl_cnt = 0;
        end else if (sck && !sl_prev_sck) begin
            sl_miso = sl_tx[7];
            sl_tx   = {sl_tx[6:0], 1'b0};
            sl_rx   = {sl_rx[6:0], mosi};
            sl_cnt++;
            if (sl_cnt == 8) begin
                sl_tx  = rev8(sl_rx);
                sl_cnt = 0;
            end
        end
        sl_prev_sck = sck;
    end

    logic [63:0] cap = '0;
    logic [63:0] rises = '0;
    logic [7:0]  mon_prev_ss = '1;
    logic        mon_prev_sck = 1'b0;
    int          n_rsp = 0;

    always @(negedge clock) begin
        exp_t e;
        if (ss != 8'hFF && mon_prev_ss == 8'hFF) begin
            cap   = '0;
            rises = '0;
        end
        if (sck && !mon_prev_sck) begin
            cap   = {cap[62:0], mosi};
            rises = rises + 64'd1;
        end
        mon_prev_ss  = ss;
        mon_prev_sck = sck;
        if (rsp_valid && rsp_ready && !reset) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_rsp: got %h with empty scoreboard", rsp_data);
            end else begin
                e = sb_q.pop_front();
                check("rsp_data", rsp_data, e.rx);
                check("mosi_bits", cap, e.tx);
                check("sck_rises", rises, e.len);
                n_rsp++;
            end
        end
    end

    int t_acc = 0;

    task automatic send(input logic [63:0] data, input logic [6:0] len, input logic [7:0] ssm,
                        input logic [15:0] div, input logic [63:0] exp_rx);
        exp_t e;
        int   le;
        le    = (len == 0 || len > 64) ? 64 : int'(len);
        e.rx  = exp_rx;
        e.tx  = (le == 64) ? data : (data & ((64'd1 << le) - 64'd1));
        e.len = 64'(le);
        sb_q.push_back(e);
        cmd_data  = data;
        cmd_len   = len;
        cmd_ss    = ssm;
        cmd_div   = div;
        cmd_valid = 1'b1;
        @(posedge clock); #1;
        cmd_valid = 1'b0;
        t_acc     = cyc;
        check("accept_busy", 64'(busy), 64'd1);
    endtask

    task automatic wait_rsp(input string nm, input int exp_lat);
        int n = 0;
        while (!rsp_valid && n < 2000) begin
            @(posedge clock); #1;
            n++;
        end
        check(nm, 64'(cyc - t_acc), 64'(exp_lat));
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 2000) begin
            @(posedge clock); #1;
            n++;
        end
        check("back_to_idle", 64'(busy), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sck"}, 64'(sck), 64'd0);
        check({tag, "_ss"}, 64'(ss), 64'hFF);
        check({tag, "_mosi"}, 64'(mosi), 64'd1);
        check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        check({tag, "_rsp_data"}, rsp_data, 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        check_reset_outputs("reset");
        repeat (3) @(posedge clock);
        #1 check("idle_sck", 64'(sck), 64'd0);

        // Upper data bits beyond len are ignored; miso low gives zero data.
        miso_mode = 0;
        send(64'hDEAD_0000_0000_00A5, 7'd8, 8'hFD, 16'd0, 64'h0);
        wait_rsp("lat_len8_div0", 17);
        wait_idle();

        miso_mode = 2;
        send(64'h0100, 7'd16, 8'hFE, 16'd1, 64'hFF80);
        wait_rsp("lat_len16_div1", 66);
        wait_idle();
        send(64'h6A00, 7'd16, 8'hFE, 16'd1, 64'hFF56);
        wait_rsp("lat_len16_div1_b", 66);
        wait_idle();

        // Garbage command held valid mid-transfer must not disturb anything.
        miso_mode = 1;
        send(64'h9, 7'd4, 8'hEF, 16'd3, 64'hF);
        cmd_valid = 1'b1;
        cmd_data  = '1;
        cmd_len   = 7'd1;
        cmd_ss    = 8'h00;
        cmd_div   = 16'd0;
        n = 0;
        while (!sck && n < 100) begin @(posedge clock); #1; n++; end
        check("setup_phase", 64'(n), 64'd4);
        n = 0;
        while (sck && n < 100) begin @(posedge clock); #1; n++; end
        check("high_phase", 64'(n), 64'd4);
        check("ss_held", 64'(ss), 64'hEF);
        n = 0;
        while (!sck && n < 100) begin @(posedge clock); #1; n++; end
        check("low_phase", 64'(n), 64'd4);
        wait_rsp("lat_len4_div3", 36);
        cmd_valid = 1'b0;
        wait_idle();

        // Backpressure on the response channel.
        miso_mode = 2;
        rsp_ready = 1'b0;
        send(64'h3C, 7'd8, 8'hFE, 16'd0, 64'hFF);
        wait_rsp("lat_backpressure", 17);
        cmd_valid = 1'b1;
        cmd_data  = 64'h55;
        for (int i = 0; i < 10; i++) begin
            check("hold_rsp_valid", 64'(rsp_valid), 64'd1);
            check("hold_rsp_data", rsp_data, 64'hFF);
            check("hold_cmd_ready", 64'(cmd_ready), 64'd0);
            @(posedge clock); #1;
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clock); #1;
        check("released_rsp_valid", 64'(rsp_valid), 64'd0);
        check("released_cmd_ready", 64'(cmd_ready), 64'd1);
        repeat (3) @(posedge clock);
        #1 check("no_late_accept", 64'(busy), 64'd0);

        // Asynchronous reset mid-transfer, between clock edges.
        miso_mode = 1;
        send(64'h0123_4567_89AB_CDEF, 7'd0, 8'hFE, 16'd2, 64'hFFFF_FFFF_FFFF_FFFF);
        repeat (20) @(posedge clock);
        #1 check("pre_reset_ss", 64'(ss), 64'hFE);
        #2 reset = 1'b1;
        #1 check_reset_outputs("midreset");
        sb_q.delete();
        @(posedge clock); #1;
        reset = 1'b0;

        send(64'hC3A5_0F1E_8421_7BDE, 7'd0, 8'hFE, 16'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        wait_rsp("lat_len64", 129);
        wait_idle();

        miso_mode = 0;
        send(64'h8000_0000_0000_0001, 7'd100, 8'hFE, 16'd0, 64'h0);
        wait_rsp("lat_len_clamped", 129);
        wait_idle();

        n = 0;
        while (sb_q.size() != 0 && n < 100) begin @(posedge clock); #1; n++; end
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        check("rsp_count", 64'(n_rsp), 64'd7);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
